// File: rtl/ibex_dummy_instr_merge_if.sv
// Fetch-side and ID-side handshake bundle for ibex_dummy_instr_merge.
// slave is the merge stage; master is the surrounding pipeline.
interface ibex_dummy_instr_merge_if;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_err_i;
    logic        fetch_ready_o;
    logic        id_in_ready_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_err_o;
    logic        id_is_dummy_o;

    modport slave (
        input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i, id_in_ready_i,
        output fetch_ready_o, id_valid_o, id_instr_o, id_pc_o, id_err_o, id_is_dummy_o
    );

    modport master (
        output fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i, id_in_ready_i,
        input  fetch_ready_o, id_valid_o, id_instr_o, id_pc_o, id_err_o, id_is_dummy_o
    );
endinterface

// File: rtl/ibex_dummy_instr_merge.sv
// Merges pending dummy instructions ahead of the real fetch stream into the IF/ID register.
// Define IBEX_DUMMY_INSTR_MERGE_STATS_EN to build the saturating dummy counter.
module ibex_dummy_instr_merge #(
    parameter int unsigned MaxBurst = 4,
    parameter int unsigned CntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    ibex_dummy_instr_merge_if.slave bus,
    input  logic                    insert_dummy_instr_i,
    input  logic [31:0]             dummy_instr_data_i,
    input  logic                    flush_i,
    output logic [CntWidth-1:0]     dummy_count_o
);

    localparam logic [3:0] MaxBurstW = 4'(MaxBurst);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic        dummy_q, dummy_d;
    logic [3:0]  burst_q, burst_d;
    logic        load, sel_dummy;

    assign load      = ~rst_i & ~flush_i & bus.fetch_valid_i & (~valid_q | bus.id_in_ready_i);
    // Errors bypass dummies so a faulting fetch is never delayed.
    assign sel_dummy = insert_dummy_instr_i & ~bus.fetch_err_i & (burst_q != MaxBurstW);

    assign bus.fetch_ready_o = load & ~sel_dummy;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        err_d   = err_q;
        dummy_d = dummy_q;
        burst_d = burst_q;
        if (flush_i) begin
            valid_d = 1'b0;
            burst_d = 4'd0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = bus.fetch_addr_i;
            if (sel_dummy) begin
                instr_d = dummy_instr_data_i;
                err_d   = 1'b0;
                dummy_d = 1'b1;
                burst_d = burst_q + 4'd1;
            end else begin
                instr_d = bus.fetch_rdata_i;
                err_d   = bus.fetch_err_i;
                dummy_d = 1'b0;
                burst_d = 4'd0;
            end
        end else if (bus.id_in_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= 32'h0;
            err_q   <= 1'b0;
            dummy_q <= 1'b0;
            burst_q <= 4'd0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            dummy_q <= dummy_d;
            burst_q <= burst_d;
        end
    end

    assign bus.id_valid_o    = valid_q;
    assign bus.id_instr_o    = instr_q;
    assign bus.id_pc_o       = pc_q;
    assign bus.id_err_o      = err_q;
    assign bus.id_is_dummy_o = dummy_q;

`ifdef IBEX_DUMMY_INSTR_MERGE_STATS_EN
    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load && sel_dummy && (count_q != {CntWidth{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign dummy_count_o = count_q;
`else
    assign dummy_count_o = '0;
`endif

endmodule

// File: tb/tb_ibex_dummy_instr_merge.sv
// Directed bench for ibex_dummy_instr_merge with a scoreboard of expected IF/ID contents.
module tb_ibex_dummy_instr_merge;

    localparam int unsigned MaxB = 4;
    localparam int unsigned CntW = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
        logic        dummy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            ins;
    logic [31:0]     dummy_data;
    logic            flush;
    logic [CntW-1:0] count;

    ibex_dummy_instr_merge_if bus ();

    ibex_dummy_instr_merge #(
        .MaxBurst (MaxB),
        .CntWidth (CntW)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .bus                  (bus),
        .insert_dummy_instr_i (ins),
        .dummy_instr_data_i   (dummy_data),
        .flush_i              (flush),
        .dummy_count_o        (count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q[$];
    logic        m_valid = 1'b0;
    logic [3:0]  m_burst = 4'd0;
    logic [31:0] m_cnt = 32'd0;
    logic [31:0] src_pc = 32'h80;
    logic [31:0] src_data = 32'h00000013;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic f, input logic i, input logic e, input logic fl,
                       input logic r);
        bus.fetch_valid_i = f;
        ins               = i;
        bus.fetch_err_i   = e;
        flush             = fl;
        bus.id_in_ready_i = r;
    endtask

    // One clock: check outputs against the model before the edge, then advance the model.
    task automatic cyc();
        logic ld, sel, rdy_exp, acc;
        exp_t e;
        bus.fetch_addr_i  = src_pc;
        bus.fetch_rdata_i = src_data;
        #3;
        ld      = !rst && !flush && bus.fetch_valid_i && (!m_valid || bus.id_in_ready_i);
        sel     = ins && !bus.fetch_err_i && (m_burst != 4'(MaxB));
        rdy_exp = ld && !sel;
        acc     = m_valid && bus.id_in_ready_i;
        chk("fetch_ready", 32'(bus.fetch_ready_o), 32'(rdy_exp));
        chk("id_valid", 32'(bus.id_valid_o), 32'(m_valid));
        if (m_valid && q.size() > 0) begin
            chk("id_instr", bus.id_instr_o, q[0].instr);
            chk("id_pc", bus.id_pc_o, q[0].pc);
            chk("id_err", 32'(bus.id_err_o), 32'(q[0].err));
            chk("id_is_dummy", 32'(bus.id_is_dummy_o), 32'(q[0].dummy));
        end
        chk("dummy_count", 32'(count), m_cnt);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_burst = 4'd0;
            m_cnt   = 32'd0;
        end else if (flush) begin
            q.delete();
            m_valid = 1'b0;
            m_burst = 4'd0;
        end else begin
            if (acc) void'(q.pop_front());
            if (ld) begin
                if (sel) begin
                    e = '{instr: dummy_data, pc: src_pc, err: 1'b0, dummy: 1'b1};
                    m_burst = m_burst + 4'd1;
`ifdef IBEX_DUMMY_INSTR_MERGE_STATS_EN
                    if (m_cnt != 32'((1 << CntW) - 1)) m_cnt = m_cnt + 32'd1;
`endif
                end else begin
                    e = '{instr: src_data, pc: src_pc, err: bus.fetch_err_i, dummy: 1'b0};
                    m_burst = 4'd0;
                end
                q.push_back(e);
                m_valid = 1'b1;
            end else if (acc) begin
                m_valid = 1'b0;
            end
            if (rdy_exp) begin
                src_pc   = src_pc + 32'd4;
                src_data = src_data + 32'h00100000;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        dummy_data = 32'h02B50533;
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        // Reset held with a pending fetch: no consumption.
        cyc();
        rst = 1'b0;
        #1;
        chk("reset_instr", bus.id_instr_o, 32'h0);
        chk("reset_pc", bus.id_pc_o, 32'h0);
        chk("reset_err", 32'(bus.id_err_o), 32'd0);
        chk("reset_dummy", 32'(bus.id_is_dummy_o), 32'd0);

        // Single real instruction at 0x80, then drain.
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc(); cyc();

        // One dummy ahead of the real instruction at 0x84.
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); cyc();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();

        // Insert held high: burst limiter forces a real every MaxBurst+1 slots.
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (15) cyc();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();

        // Fetch error suppresses the dummy.
        drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); cyc();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();

        // Dummy held through a 3-cycle stall, dummy inputs toggling, then flushed.
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); cyc();
        dummy_data = 32'hDEADBEEF;
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); cyc();
        dummy_data = 32'h02B50533;
        // Burst counter restarts from zero after the flush.
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) cyc();

        // Flush coinciding with an accept.
        drv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); cyc();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();

        // Long dummy run to saturate the statistics counter.
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (25) cyc();

        // Reset mid-stream drops the registered instruction.
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        rst = 1'b1; cyc();
        rst = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        chk("midreset_pc", bus.id_pc_o, 32'h0);
        chk("midreset_instr", bus.id_instr_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ibex_dummy_instr_merge.md
# ibex_dummy_instr_merge

Merges dummy instructions into the IF-to-ID instruction stream, downstream of `ibex_dummy_instr`. Each cycle it chooses between the real fetched instruction and a pending dummy, and registers the choice into the IF/ID pipeline register with the PC, error and dummy tags. The real instruction is held off until the dummy has been issued. A burst limiter guarantees forward progress, and an optional statistics counter records how many dummies were inserted.

## Interface
- `MaxBurst`, default 4: maximum consecutive dummies before a real instruction is forced; legal range 1..15.
- `CntWidth`, default 16: width of the dummy statistics counter.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `fetch_valid_i`  in  1  real instruction available from the prefetch buffer.
- `fetch_rdata_i`  in  32  real instruction word.
- `fetch_addr_i`  in  32  PC of the real instruction.
- `fetch_err_i`  in  1  fetch bus error for this instruction.
- `fetch_ready_o`  out  1  real instruction consumed this cycle.
- `insert_dummy_instr_i`  in  1  dummy request from the dummy generator.
- `dummy_instr_data_i`  in  32  dummy instruction word.
- `flush_i`  in  1  branch or exception flush; discards the registered instruction.
- `id_in_ready_i`  in  1  ID stage accepts `id_instr_o` this cycle.
- `id_valid_o`  out  1  IF/ID register holds a valid instruction.
- `id_instr_o`  out  32  registered instruction word.
- `id_pc_o`  out  32  registered PC.
- `id_err_o`  out  1  registered fetch error.
- `id_is_dummy_o`  out  1  registered instruction is a dummy.
- `dummy_count_o`  out  `CntWidth`  saturating count of dummies issued.

## Operation
- Load condition: `load = ~flush_i & fetch_valid_i & (~id_valid_o | id_in_ready_i)`.
- Dummy selection: `sel_dummy = insert_dummy_instr_i & ~fetch_err_i & (burst_q != MaxBurst)`.
- On `load & sel_dummy`:
  - Register: instr = `dummy_instr_data_i`, pc = `fetch_addr_i`, err = 0, is_dummy = 1.
  - `fetch_ready_o` = 0; the real instruction stays pending.
  - `burst_q` increments.
- On `load & ~sel_dummy`:
  - Register the real instruction with is_dummy = 0.
  - `fetch_ready_o` = 1.
  - `burst_q` clears to 0.
- Hold: with no load, `id_valid_o & ~id_in_ready_i` keeps every register stable.
- Drain: with no load, `id_in_ready_i` and no new fetch clears `id_valid_o` next cycle.
- `fetch_ready_o` is combinational and equals `load & ~sel_dummy`.
- `flush_i` has priority over everything else:
  - Next cycle `id_valid_o` = 0 and `burst_q` = 0.
  - `fetch_ready_o` = 0 in the flush cycle.
  - Statistics are unaffected.
- Fetch errors: `fetch_err_i` = 1 suppresses dummy insertion, so errors are never delayed behind dummies.
- Burst limit: at `burst_q == MaxBurst` the real instruction is forced even when `insert_dummy_instr_i` is high. `burst_q` is 4 bits.
- Dummies are never inserted without a pending real instruction (`fetch_valid_i` = 0 means no load).

## Timing
- Latency: one cycle from a registered load to `id_valid_o`.
- Throughput: one instruction per cycle while `id_in_ready_i` stays high.
- Values after reset:
  - `id_valid_o`, `id_err_o`, `id_is_dummy_o` = 0.
  - `id_instr_o` and `id_pc_o` = 32'h0.
  - `burst_q` = 0 and `dummy_count_o` = 0.
- `fetch_ready_o` is 0 in every cycle that `rst_i` is high.
- Reset mid-stream drops the registered instruction with no handshake.
- Outputs are stable while `id_valid_o & ~id_in_ready_i`; `insert_dummy_instr_i` changes during a stall have no effect.
- A flush and an ID accept in the same cycle: the accept completes, and the register is empty next cycle.

## Configuration
- Macro: `IBEX_DUMMY_INSTR_MERGE_STATS_EN`.
- Defined: `dummy_count_o` increments by 1 on every dummy load and saturates at all-ones.
- Undefined: no counter flops are built and `dummy_count_o` is tied to 0.
- Insertion behaviour is identical in both builds.

## Test plan
- Reset, then real instruction 32'h00000013 at PC 32'h80 with `id_in_ready_i`=1: `id_valid_o`=1 next cycle, `id_pc_o`=32'h80, `id_is_dummy_o`=0, `fetch_ready_o`=1 in the load cycle.
- `insert_dummy_instr_i`=1 with dummy 32'h02B50533 and real at PC 32'h84: cycle 1 issues the dummy (`is_dummy`=1, pc=32'h84, `fetch_ready_o`=0); cycle 2 issues the real instruction (`fetch_ready_o`=1).
- `insert_dummy_instr_i` held high, `MaxBurst`=4: exactly 4 dummies, then 1 real instruction, then the pattern repeats; with stats built, `dummy_count_o` increases by 4 per 5 issued.
- `fetch_err_i`=1 together with `insert_dummy_instr_i`=1: the real instruction issues immediately, `id_err_o`=1, `id_is_dummy_o`=0.
- `id_in_ready_i`=0 for 3 cycles while holding a dummy: outputs are unchanged and `fetch_ready_o`=0; a `flush_i` pulse then gives `id_valid_o`=0 next cycle and `burst_q` cleared.
- Stats build with `CntWidth`=4 and 20 dummies inserted: `dummy_count_o` saturates at 4'hF.
